bit_serializer: RTL

- Parallel-to-serial feeder that sits directly upstream of the serial sequence detectors (e.g. the 111 detectors).
- Accepts a DATA_W-bit word over a valid/ready handshake and shifts it out MSB-first, one bit per clock, on sdout. sdout drives the detector's din.
- Inserts a programmable run of idle-zero cycles between words so that downstream non-overlapping detectors see clean frame boundaries.

---
 rtl/ser_pkg.sv | 23 ++
 rtl/ser_gap_timer.sv | 33 +++
 rtl/bit_serializer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/ser_pkg.sv
// Shared types and constants for the bit serializer.
// Holds the FSM state encoding, frame-length helper and idle line level.
package ser_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } ser_state_e;

    // Level driven on sdout whenever no frame bit is present.
    localparam logic IDLE_LVL = 1'b0;

    // Number of bits per frame; one extra parity bit when SER_PARITY_EN.
    function automatic int ser_nbits(input int data_w);
`ifdef SER_PARITY_EN
        return data_w + 1;
`else
        return data_w;
`endif
    endfunction

endpackage

// File: rtl/ser_gap_timer.sv
// Loadable down-counter timing the idle gap between serialized words.
// Ports: clk, rst (sync, active-high), load (start a gap), expire (last gap cycle).
module ser_gap_timer
    import ser_pkg::*;
#(
    parameter int GAP_CYC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expire
);

    localparam int CW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    // Loading GAP_CYC-1 makes expire true in the final gap cycle,
    // so the FSM spends exactly GAP_CYC cycles in GAP.
    localparam logic [CW-1:0] LOAD_V = CW'(GAP_CYC - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_V;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder: shifts a DATA_W-bit word out MSB-first,
// followed by GAP_CYC idle-zero cycles. Optional parity bit: SER_PARITY_EN.
// Ports: clk, rst (sync, active-high), pdata_in/pvalid/pready (word handshake),
//        sdout (serial bit), sframe (frame bit present), done (last bit),
//        bit_cnt (index of bit on sdout, 0 outside a frame).
module bit_serializer
    import ser_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int GAP_CYC = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             pdata_in,
    input  logic                          pvalid,
    output logic                          pready,
    output logic                          sdout,
    output logic                          sframe,
    output logic                          done,
    output logic [$clog2(DATA_W+2)-1:0]   bit_cnt
);

    localparam int NBITS = ser_nbits(DATA_W);
    localparam int CNT_W = $clog2(DATA_W + 2);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NBITS - 1);

    ser_state_e       state;
    logic [NBITS-1:0] shreg;
    logic [NBITS-1:0] load_word;
    logic             last_bit;
    logic             gap_load;
    logic             gap_expire;

`ifdef SER_PARITY_EN
    // Even parity rides in the LSB so it falls out after the data bits.
    assign load_word = {pdata_in, ^pdata_in};
`else
    assign load_word = pdata_in;
`endif

    assign last_bit = (bit_cnt == LAST);
    assign gap_load = (state == SHIFT) && last_bit;

    // The register's MSB always mirrors the bit currently on sdout,
    // so the next bit to present is shreg[NBITS-2].
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pready  <= 1'b1;
            sdout   <= IDLE_LVL;
            sframe  <= 1'b0;
            done    <= 1'b0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pvalid) begin
                        shreg   <= load_word;
                        sdout   <= load_word[NBITS-1];
                        sframe  <= 1'b1;
                        pready  <= 1'b0;
                        done    <= 1'b0;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (last_bit) begin
                        shreg   <= '0;
                        sdout   <= IDLE_LVL;
                        sframe  <= 1'b0;
                        done    <= 1'b0;
                        bit_cnt <= '0;
                        if (GAP_CYC > 0) begin
                            state <= GAP;
                        end else begin
                            state  <= IDLE;
                            pready <= 1'b1;
                        end
                    end else begin
                        shreg   <= shreg << 1;
                        sdout   <= shreg[NBITS-2];
                        bit_cnt <= bit_cnt + 1'b1;
                        done    <= (bit_cnt == LAST - 1'b1);
                    end
                end
                GAP: begin
                    if (gap_expire) begin
                        state  <= IDLE;
                        pready <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    pready <= 1'b1;
                end
            endcase
        end
    end

    generate
        if (GAP_CYC > 0) begin : g_gap
            ser_gap_timer #(
                .GAP_CYC(GAP_CYC)
            ) u_gap (
                .clk   (clk),
                .rst   (rst),
                .load  (gap_load),
                .expire(gap_expire)
            );
        end else begin : g_nogap
            // GAP is never entered; the timer is not needed.
            logic unused_gap;
            assign unused_gap = gap_load;
            assign gap_expire = 1'b1;
        end
    endgenerate

endmodule
